// File: rtl/imem_loader_pkg.sv
// Shared types for the instruction-memory loader: FSM states, header size, per-state status.
// IMEM_LOADER_CHECKSUM_EN adds the trailing checksum state.
package imem_loader_pkg;

    localparam int HDR_BYTES = 2;
    typedef logic [HDR_BYTES*8-1:0] len_t;

    typedef enum logic [2:0] {
        S_IDLE, S_LEN_LO, S_LEN_HI, S_DATA, S_WRITE, S_DONE, S_ERROR
`ifdef IMEM_LOADER_CHECKSUM_EN
        , S_CSUM
`endif
    } state_t;

    // State entered once the last word (or an empty payload) has been handled
`ifdef IMEM_LOADER_CHECKSUM_EN
    localparam state_t S_FIN = S_CSUM;
`else
    localparam state_t S_FIN = S_DONE;
`endif

    typedef struct packed {
        logic in_ready;
        logic busy;
        logic cpu_hold;
        logic done;
        logic error;
    } status_t;

    function automatic status_t state_status(state_t s);
        status_t st;
        st = '{in_ready: 1'b0, busy: 1'b1, cpu_hold: 1'b1, done: 1'b0, error: 1'b0};
        case (s)
            S_IDLE:  st.busy = 1'b0;
            S_DONE:  begin st.busy = 1'b0; st.cpu_hold = 1'b0; st.done = 1'b1; end
            S_ERROR: begin st.busy = 1'b0; st.error = 1'b1; end
            S_LEN_LO, S_LEN_HI, S_DATA: st.in_ready = 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
            S_CSUM:  st.in_ready = 1'b1;
`endif
            default: ;
        endcase
        return st;
    endfunction

endpackage

// File: rtl/imem_loader_if.sv
// Loader bus: control/status, upstream byte stream and instruction-memory write port.
interface imem_loader_if #(
    parameter int NUM_INST   = 128,
    parameter int INST_WIDTH = 32
);
    localparam int AW = $clog2(NUM_INST);

    logic                  start;
    logic                  in_valid;
    logic [7:0]            in_data;
    logic                  in_ready;
    logic                  imem_we;
    logic [AW-1:0]         imem_addr;
    logic [INST_WIDTH-1:0] imem_wdata;
    logic                  cpu_hold;
    logic                  busy;
    logic                  done;
    logic                  error;
    logic [AW:0]           words_loaded;

    modport slave (
        input  start, in_valid, in_data,
        output in_ready, imem_we, imem_addr, imem_wdata, cpu_hold, busy, done, error, words_loaded
    );

    modport master (
        output start, in_valid, in_data,
        input  in_ready, imem_we, imem_addr, imem_wdata, cpu_hold, busy, done, error, words_loaded
    );

endinterface

// File: rtl/loader_word_assembler.sv
// Packs accepted bytes little-endian into a word; word_ready flags the byte that completes it.
module loader_word_assembler #(
    parameter int WORD_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              byte_en,
    input  logic [7:0]        byte_in,
    output logic [WORD_W-1:0] word,
    output logic              word_ready
);
    localparam int BYTES = WORD_W / 8;
    localparam int CW    = $clog2(BYTES);

    // Holds the earlier bytes; the completing byte is merged combinationally
    logic [WORD_W-9:0] sr;
    logic [CW-1:0]     cnt;

    assign word       = {byte_in, sr};
    assign word_ready = byte_en && (cnt == CW'(BYTES - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sr  <= '0;
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (byte_en) begin
            sr  <= word[WORD_W-1:8];
            cnt <= word_ready ? '0 : cnt + CW'(1);
        end
    end

endmodule

// File: rtl/imem_loader.sv
// Boot loader: length header, little-endian words into instruction memory, processor held until done.
// IMEM_LOADER_CHECKSUM_EN enables a trailing XOR checksum byte.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int NUM_INST   = 128,
    parameter int INST_WIDTH = 32
) (
    input logic         clk,
    input logic         rst,
    imem_loader_if.slave bus
);
    localparam int AW = $clog2(NUM_INST);

    state_t                state, nxt;
    status_t               st;
    len_t                  len_q, len_full, wl_inc;
    logic [AW:0]           words_loaded;
    logic [AW-1:0]         imem_addr;
    logic [INST_WIDTH-1:0] imem_wdata, asm_word;
    logic                  imem_we, fire, restart, data_en, word_ready;

    assign fire     = bus.in_valid && st.in_ready;
    assign restart  = bus.start && (state inside {S_IDLE, S_DONE, S_ERROR});
    assign data_en  = fire && (state == S_DATA);
    assign len_full = {bus.in_data, len_q[7:0]};
    assign wl_inc   = len_t'(words_loaded) + len_t'(1);

    loader_word_assembler #(.WORD_W(INST_WIDTH)) u_asm (
        .clk       (clk),
        .rst       (rst),
        .clear     (restart),
        .byte_en   (data_en),
        .byte_in   (bus.in_data),
        .word      (asm_word),
        .word_ready(word_ready)
    );

`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0] csum;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)          csum <= '0;
        else if (restart) csum <= '0;
        else if (data_en) csum <= csum ^ bus.in_data;
    end
`endif

    always_comb begin
        nxt = state;
        case (state)
            S_IDLE, S_DONE, S_ERROR: if (bus.start) nxt = S_LEN_LO;
            S_LEN_LO: if (fire) nxt = S_LEN_HI;
            S_LEN_HI: if (fire) begin
                if (len_full > len_t'(NUM_INST)) nxt = S_ERROR;
                else if (len_full == '0)         nxt = S_FIN;
                else                             nxt = S_DATA;
            end
            S_DATA:  if (word_ready) nxt = S_WRITE;
            S_WRITE: nxt = (wl_inc == len_q) ? S_FIN : S_DATA;
`ifdef IMEM_LOADER_CHECKSUM_EN
            S_CSUM:  if (fire) nxt = (bus.in_data == csum) ? S_DONE : S_ERROR;
`endif
            default: nxt = S_IDLE;
        endcase
    end

    // Status outputs are registered from the next state so they line up with it
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= S_IDLE;
            st           <= state_status(S_IDLE);
            imem_we      <= 1'b0;
            imem_addr    <= '0;
            imem_wdata   <= '0;
            words_loaded <= '0;
            len_q        <= '0;
        end else begin
            state   <= nxt;
            st      <= state_status(nxt);
            imem_we <= (nxt == S_WRITE);
            if (restart) words_loaded <= '0;
            if (fire && state == S_LEN_LO) len_q[7:0]  <= bus.in_data;
            if (fire && state == S_LEN_HI) len_q[15:8] <= bus.in_data;
            if (state == S_DATA && word_ready) begin
                imem_wdata <= asm_word;
                imem_addr  <= words_loaded[AW-1:0];
            end
            if (state == S_WRITE) words_loaded <= words_loaded + 1'b1;
        end
    end

    assign bus.in_ready     = st.in_ready;
    assign bus.busy         = st.busy;
    assign bus.cpu_hold     = st.cpu_hold;
    assign bus.done         = st.done;
    assign bus.error        = st.error;
    assign bus.imem_we      = imem_we;
    assign bus.imem_addr    = imem_addr;
    assign bus.imem_wdata   = imem_wdata;
    assign bus.words_loaded = words_loaded;

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboarded bench for imem_loader: expected writes queued at stimulus time, checked at imem_we.
module tb_imem_loader;
    localparam int NI = 128;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    imem_loader_if #(.NUM_INST(NI), .INST_WIDTH(32)) bus ();
    imem_loader #(.NUM_INST(NI), .INST_WIDTH(32)) dut (.clk(clk), .rst(rst), .bus(bus.slave));

    typedef struct {
        logic [6:0]  addr;
        logic [31:0] data;
    } wr_t;

    wr_t         sb[$];
    wr_t         exp_wr;
    logic [31:0] wbuf[$];
    int          checks = 0;
    int          failures = 0;

    always @(negedge clk) begin
        if (!rst && bus.imem_we === 1'b1) begin
            checks++;
            if (sb.size() == 0) begin
                failures++;
                $display("FAIL unexpected_write addr=%0d data=%h", bus.imem_addr, bus.imem_wdata);
            end else begin
                exp_wr = sb.pop_front();
                if (bus.imem_addr !== exp_wr.addr || bus.imem_wdata !== exp_wr.data) begin
                    failures++;
                    $display("FAIL write got=%0d:%h want=%0d:%h", bus.imem_addr, bus.imem_wdata,
                             exp_wr.addr, exp_wr.data);
                end
            end
            checks++;
            if (bus.in_ready !== 1'b0) begin
                failures++;
                $display("FAIL write_ready got=%b want=0", bus.in_ready);
            end
        end
    end

    task automatic send_byte(input logic [7:0] b, input int gap);
        bit got;
        got = 0;
        bus.in_valid = 1'b1;
        bus.in_data  = b;
        for (int t = 0; t < 64 && !got; t++) begin
            @(negedge clk);
            if (bus.in_ready === 1'b1) begin
                @(posedge clk);
                #1;
                got = 1;
            end
        end
        bus.in_valid = 1'b0;
        repeat (gap) begin @(posedge clk); #1; end
        checks++;
        if (!got) begin
            failures++;
            $display("FAIL byte_timeout byte=%h got=no_accept want=accept", b);
        end
    endtask

    task automatic pulse_start();
        @(posedge clk);
        #1 bus.start = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b0;
    endtask

    task automatic wait_fin();
        bit got;
        got = 0;
        for (int t = 0; t < 200 && !got; t++) begin
            @(negedge clk);
            if (bus.done === 1'b1 || bus.error === 1'b1) got = 1;
        end
        checks++;
        if (!got) begin
            failures++;
            $display("FAIL fin_timeout got=busy want=done_or_error");
        end
    endtask

    // Full load of wbuf; flip corrupts the checksum byte when that feature is built in
    task automatic load_words(input int gap, input logic [7:0] flip);
        logic [7:0]  cs;
        logic [15:0] n;
        logic [31:0] w;
        cs = flip;
        n  = 16'(wbuf.size());
        pulse_start();
        checks++;
        if ({bus.done, bus.error, bus.busy, bus.words_loaded} !== {3'b001, 8'd0}) begin
            failures++;
            $display("FAIL restart_clear got=%b%b%b/%0d want=001/0", bus.done, bus.error,
                     bus.busy, bus.words_loaded);
        end
        send_byte(n[7:0], gap);
        send_byte(n[15:8], gap);
        for (int i = 0; i < wbuf.size(); i++) begin
            w = wbuf[i];
            sb.push_back('{addr: 7'(i), data: w});
            for (int k = 0; k < 4; k++) begin
                send_byte(w[8*k +: 8], gap);
                cs = cs ^ w[8*k +: 8];
            end
        end
`ifdef IMEM_LOADER_CHECKSUM_EN
        send_byte(cs, gap);
`endif
    endtask

    task automatic check_end(input string name, input logic dn, input logic er, input int nw);
        checks++;
        if ({bus.done, bus.error, bus.busy, bus.cpu_hold} !== {dn, er, 1'b0, ~dn}
            || int'(bus.words_loaded) != nw || sb.size() != 0) begin
            failures++;
            $display("FAIL %s got=d%b e%b b%b h%b w%0d sb%0d want=d%b e%b b0 h%b w%0d sb0", name,
                     bus.done, bus.error, bus.busy, bus.cpu_hold, bus.words_loaded, sb.size(),
                     dn, er, ~dn, nw);
        end
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({bus.in_ready, bus.imem_we, bus.busy, bus.done, bus.error, bus.cpu_hold} !== 6'b000001) begin
            failures++;
            $display("FAIL reset_status got=%b%b%b%b%b%b want=000001", bus.in_ready, bus.imem_we,
                     bus.busy, bus.done, bus.error, bus.cpu_hold);
        end
        checks++;
        if (bus.imem_addr !== 7'd0 || bus.imem_wdata !== 32'd0 || bus.words_loaded !== 8'd0) begin
            failures++;
            $display("FAIL reset_regs got=%0d/%h/%0d want=0/0/0", bus.imem_addr, bus.imem_wdata,
                     bus.words_loaded);
        end
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic test_basic();
        wbuf = '{32'h0000_0013, 32'h0010_0093};
        load_words(0, 8'h00);
        wait_fin();
        check_end("basic_end", 1'b1, 1'b0, 2);
        repeat (5) @(posedge clk);
        #1;
        checks++;
        if (bus.done !== 1'b1 || bus.imem_wdata !== 32'h0010_0093) begin
            failures++;
            $display("FAIL done_hold got=%b/%h want=1/00100093", bus.done, bus.imem_wdata);
        end
    endtask

    task automatic test_too_long();
        pulse_start();
        send_byte(8'h81, 0);
        send_byte(8'h00, 0);
        check_end("too_long", 1'b0, 1'b1, 0);
        repeat (4) @(posedge clk);
        #1;
        checks++;
        if (bus.error !== 1'b1 || bus.in_ready !== 1'b0) begin
            failures++;
            $display("FAIL error_hold got=%b/%b want=1/0", bus.error, bus.in_ready);
        end
    endtask

    task automatic test_zero_len();
        wbuf = {};
        load_words(0, 8'h00);
        wait_fin();
        check_end("zero_len", 1'b1, 1'b0, 0);
    endtask

    task automatic test_gapped();
        wbuf = '{32'hDEAD_BEEF};
        load_words(1, 8'h00);
        wait_fin();
        check_end("gapped", 1'b1, 1'b0, 1);
    endtask

    task automatic test_reset_mid();
        logic [31:0] w;
        wbuf = '{32'hA1B2_C3D4, 32'h0506_0708};
        pulse_start();
        send_byte(8'h04, 0);
        send_byte(8'h00, 0);
        for (int i = 0; i < 2; i++) begin
            w = wbuf[i];
            sb.push_back('{addr: 7'(i), data: w});
            for (int k = 0; k < 4; k++) send_byte(w[8*k +: 8], 0);
        end
        @(posedge clk);
        #1;
        checks++;
        if (bus.words_loaded !== 8'd2 || bus.busy !== 1'b1) begin
            failures++;
            $display("FAIL mid_progress got=%0d/%b want=2/1", bus.words_loaded, bus.busy);
        end
        rst = 1'b1;
        #1;
        checks++;
        if ({bus.busy, bus.cpu_hold, bus.in_ready, bus.imem_we} !== 4'b0100 || bus.words_loaded !== 8'd0) begin
            failures++;
            $display("FAIL mid_reset got=%b%b%b%b/%0d want=0100/0", bus.busy, bus.cpu_hold,
                     bus.in_ready, bus.imem_we, bus.words_loaded);
        end
        @(posedge clk);
        #1 rst = 1'b0;
        wbuf = '{32'h1234_5678};
        load_words(0, 8'h00);
        wait_fin();
        check_end("after_reset", 1'b1, 1'b0, 1);
    endtask

    task automatic test_start_busy();
        logic [31:0] w;
        logic [7:0]  cs;
        cs = 8'h00;
        wbuf = '{32'hCAFE_F00D, 32'h0BAD_BEEF};
        pulse_start();
        send_byte(8'h02, 0);
        send_byte(8'h00, 0);
        for (int i = 0; i < 2; i++) begin
            w = wbuf[i];
            sb.push_back('{addr: 7'(i), data: w});
            for (int k = 0; k < 4; k++) begin
                send_byte(w[8*k +: 8], 0);
                cs = cs ^ w[8*k +: 8];
                if (i == 0 && k == 1) begin
                    pulse_start();
                    checks++;
                    if (bus.busy !== 1'b1 || bus.in_ready !== 1'b1 || bus.words_loaded !== 8'd0) begin
                        failures++;
                        $display("FAIL start_ignored got=%b%b/%0d want=11/0", bus.busy,
                                 bus.in_ready, bus.words_loaded);
                    end
                end
            end
        end
`ifdef IMEM_LOADER_CHECKSUM_EN
        send_byte(cs, 0);
`endif
        wait_fin();
        check_end("start_busy", 1'b1, 1'b0, 2);
    endtask

`ifdef IMEM_LOADER_CHECKSUM_EN
    task automatic test_checksum();
        wbuf = '{32'h0000_0013};
        load_words(0, 8'h00);
        wait_fin();
        check_end("csum_good", 1'b1, 1'b0, 1);
        load_words(0, 8'h01);
        wait_fin();
        check_end("csum_bad", 1'b0, 1'b1, 1);
    endtask
`endif

    initial begin
        bus.start    = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;
        test_reset();
        test_basic();
        test_too_long();
        test_zero_len();
        test_gapped();
        test_reset_mid();
        test_start_busy();
`ifdef IMEM_LOADER_CHECKSUM_EN
        test_checksum();
`endif
        repeat (3) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog got=running want=finished");
        $fatal(1, "watchdog");
    end

endmodule
